// File: rtl/resize_pkg.sv
// Shared types and default geometry for the bilinear patch scheduler.
package resize_pkg;

  localparam int DEF_SRC_W = 640;
  localparam int DEF_SRC_H = 480;
  localparam int DEF_PIX_W = 8;

  // Scheduler phases: wait for frame, store first line, stream, right-edge insert, last-row flush.
  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    EDGE,
    FLUSH
  } rps_state_t;

  // How the second pipeline stage assembles a patch from pixel, line-buffer word and history.
  typedef enum logic [1:0] {
    MODE_PIX,
    MODE_EDGE,
    MODE_FLUSH
  } patch_mode_t;

  // Patch word at default pixel width, MSB first: {D22, D12, D21, D11}.
  typedef struct packed {
    logic [DEF_PIX_W-1:0] d22;
    logic [DEF_PIX_W-1:0] d12;
    logic [DEF_PIX_W-1:0] d21;
    logic [DEF_PIX_W-1:0] d11;
  } patch_t;

endpackage

// File: rtl/resize_patch_sched_line_buf.sv
// One-line pixel store: simple dual port, registered read, old data returned on same-address write.
module line_buf_1r1w #(
  parameter int DEPTH = 640,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wAddr,
  input  logic [W-1:0]             wData,
  input  logic [$clog2(DEPTH)-1:0] rAddr,
  output logic [W-1:0]             rData
);

  logic [W-1:0] mem [DEPTH];

  // Write and registered read share the edge, so a same-address read sees the previous row.
  always_ff @(posedge i_clk) begin
    if (we) mem[wAddr] <= wData;
    rData <= mem[rAddr];
  end

endmodule

// File: rtl/resize_patch_sched.sv
// Raster pixel stream to 2x2 bilinear patches with edge replication and final-row flush.
module resize_patch_sched
  import resize_pkg::*;
#(
  parameter int SRC_W = DEF_SRC_W,
  parameter int SRC_H = DEF_SRC_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIX_W-1:0]   i_pix,
  input  logic               i_pix_valid,
  input  logic               i_sof,
  output logic               o_in_ready,
  output logic [4*PIX_W-1:0] o_patch,
  output logic               o_patch_valid,
  output logic               o_patch_sof,
  output logic               o_patch_eol,
  output logic               o_patch_eof,
  output logic               o_overrun,
  output logic               o_sof_err
);

  localparam int XW = $clog2(SRC_W);
  localparam int YW = $clog2(SRC_H);
  localparam logic [XW-1:0] X_LAST = XW'(SRC_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SRC_H - 1);

  typedef struct packed {
    logic [PIX_W-1:0] d22;
    logic [PIX_W-1:0] d12;
    logic [PIX_W-1:0] d21;
    logic [PIX_W-1:0] d11;
  } pixPatch_t;

  // Pixel lands top-right/bottom-right; history supplies the left column; flush reuses top as bottom.
  function automatic pixPatch_t buildPatch(input patch_mode_t mode, input logic [PIX_W-1:0] pix,
                                           input logic [PIX_W-1:0] top, input logic [PIX_W-1:0] pTop,
                                           input logic [PIX_W-1:0] pBot);
    pixPatch_t p;
    case (mode)
      MODE_PIX:   begin p.d22 = pix;  p.d12 = top;  p.d21 = pBot; p.d11 = pTop; end
      MODE_FLUSH: begin p.d22 = top;  p.d12 = top;  p.d21 = pTop; p.d11 = pTop; end
      default:    begin p.d22 = pBot; p.d12 = pTop; p.d21 = pBot; p.d11 = pTop; end
    endcase
    return p;
  endfunction

  rps_state_t       state;
  logic [XW-1:0]    xCnt;
  logic [YW-1:0]    yCnt;
  logic             flushLast;
  logic             inReady;
  logic             accept;
  logic             lbWe;
  logic [XW-1:0]    lbWAddr;
  logic [PIX_W-1:0] top;

  logic             vld_p0;
  logic             updPrev_p0;
  logic             sof_p0;
  logic             eol_p0;
  logic             eof_p0;
  patch_mode_t      mode_p0;
  logic [PIX_W-1:0] pix_p0;
  logic [PIX_W-1:0] prevTop;
  logic [PIX_W-1:0] prevBot;

  logic             vld_p1;
  logic             sof_p1;
  logic             eol_p1;
  logic             eof_p1;
  pixPatch_t        patch_p1;
  logic             overrun_p1;
  logic             sofErr_p1;

  assign accept = i_pix_valid & inReady;

  // Store every accepted pixel of a frame; a start-of-frame pixel always restarts at column 0.
  always_comb begin
    lbWe    = 1'b0;
    lbWAddr = xCnt;
    if (accept) begin
      if (i_sof) begin
        lbWe    = 1'b1;
        lbWAddr = '0;
      end else if (state == FILL || state == RUN) begin
        lbWe = 1'b1;
      end
    end
  end

  line_buf_1r1w #(
    .DEPTH(SRC_W),
    .W    (PIX_W)
  ) uLineBuf (
    .i_clk(i_clk),
    .we   (lbWe),
    .wAddr(lbWAddr),
    .wData(i_pix),
    .rAddr(xCnt),
    .rData(top)
  );

  // Scheduler FSM: counters, ready, and the stage-0 patch request for each accept or FSM cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      xCnt       <= '0;
      yCnt       <= '0;
      flushLast  <= 1'b0;
      inReady    <= 1'b1;
      vld_p0     <= 1'b0;
      updPrev_p0 <= 1'b0;
      sof_p0     <= 1'b0;
      eol_p0     <= 1'b0;
      eof_p0     <= 1'b0;
      mode_p0    <= MODE_PIX;
      overrun_p1 <= 1'b0;
      sofErr_p1  <= 1'b0;
    end else begin
      vld_p0     <= 1'b0;
      updPrev_p0 <= 1'b0;
      sof_p0     <= 1'b0;
      eol_p0     <= 1'b0;
      eof_p0     <= 1'b0;
      mode_p0    <= MODE_PIX;
      overrun_p1 <= i_pix_valid & ~inReady;
      sofErr_p1  <= 1'b0;
      unique case (state)
        IDLE: begin
          yCnt <= '0;
          if (accept && i_sof) begin
            state <= FILL;
            xCnt  <= XW'(1);
          end
        end
        FILL, RUN: begin
          if (accept) begin
            if (i_sof) begin
              // Resync: abandon the current frame, this pixel becomes (0,0).
              sofErr_p1 <= 1'b1;
              state     <= FILL;
              xCnt      <= XW'(1);
              yCnt      <= '0;
            end else begin
              if (state == RUN) begin
                updPrev_p0 <= 1'b1;
                vld_p0     <= (xCnt != '0);
                sof_p0     <= (xCnt == XW'(1)) && (yCnt == YW'(1));
              end
              if (xCnt == X_LAST) begin
                xCnt <= '0;
                if (state == FILL) begin
                  state <= RUN;
                  yCnt  <= YW'(1);
                end else begin
                  state   <= EDGE;
                  inReady <= 1'b0;
                end
              end else begin
                xCnt <= xCnt + 1'b1;
              end
            end
          end
        end
        EDGE: begin
          vld_p0  <= 1'b1;
          mode_p0 <= MODE_EDGE;
          eol_p0  <= 1'b1;
          if (yCnt == Y_LAST) begin
            state <= FLUSH;
          end else begin
            yCnt    <= yCnt + 1'b1;
            state   <= RUN;
            inReady <= 1'b1;
          end
        end
        FLUSH: begin
          if (!flushLast) begin
            mode_p0    <= MODE_FLUSH;
            updPrev_p0 <= 1'b1;
            vld_p0     <= (xCnt != '0);
            if (xCnt == X_LAST) begin
              xCnt      <= '0;
              flushLast <= 1'b1;
              // The closing edge cycle needs no line-buffer read, so a new frame may start here.
              inReady   <= 1'b1;
            end else begin
              xCnt <= xCnt + 1'b1;
            end
          end else begin
            vld_p0    <= 1'b1;
            mode_p0   <= MODE_EDGE;
            eol_p0    <= 1'b1;
            eof_p0    <= 1'b1;
            flushLast <= 1'b0;
            yCnt      <= '0;
            if (accept && i_sof) begin
              state <= FILL;
              xCnt  <= XW'(1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: line-buffer word arrives, history columns advance ----
  // Pixel capture and left-column history; pure data, no reset needed.
  always_ff @(posedge i_clk) begin
    pix_p0 <= i_pix;
    if (updPrev_p0) begin
      prevTop <= top;
      prevBot <= (mode_p0 == MODE_FLUSH) ? top : pix_p0;
    end
  end

  // ---- stage p1: output register toward the resize core ----
  // Output register; cleared on reset so nothing in flight escapes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      eol_p1   <= 1'b0;
      eof_p1   <= 1'b0;
      patch_p1 <= '0;
    end else begin
      vld_p1   <= vld_p0;
      sof_p1   <= sof_p0;
      eol_p1   <= eol_p0;
      eof_p1   <= eof_p0;
      patch_p1 <= buildPatch(mode_p0, pix_p0, top, prevTop, prevBot);
    end
  end

  assign o_in_ready    = inReady;
  assign o_patch       = patch_p1;
  assign o_patch_valid = vld_p1;
  assign o_patch_sof   = sof_p1;
  assign o_patch_eol   = eol_p1;
  assign o_patch_eof   = eof_p1;
  assign o_overrun     = overrun_p1;
  assign o_sof_err     = sofErr_p1;

endmodule

// File: tb/tb_resize_patch_sched.sv
// Directed bench for resize_patch_sched at 4x3, pixel value 16*y+x.
module tb_resize_patch_sched;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            i_rst;
  logic [PW-1:0]   i_pix;
  logic            i_pix_valid;
  logic            i_sof;
  logic            o_in_ready;
  logic [4*PW-1:0] o_patch;
  logic            o_patch_valid;
  logic            o_patch_sof;
  logic            o_patch_eol;
  logic            o_patch_eof;
  logic            o_overrun;
  logic            o_sof_err;

  always #5 clk = ~clk;

  resize_patch_sched #(.SRC_W(W), .SRC_H(H), .PIX_W(PW)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_pix        (i_pix),
    .i_pix_valid  (i_pix_valid),
    .i_sof        (i_sof),
    .o_in_ready   (o_in_ready),
    .o_patch      (o_patch),
    .o_patch_valid(o_patch_valid),
    .o_patch_sof  (o_patch_sof),
    .o_patch_eol  (o_patch_eol),
    .o_patch_eof  (o_patch_eof),
    .o_overrun    (o_overrun),
    .o_sof_err    (o_sof_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
    int          cyc;
  } obs_t;

  typedef struct {
    int          x;
    int          y;
    logic [31:0] exp;
  } vec_t;

  int   nChecks = 0;
  int   nFail   = 0;
  int   cycCnt  = 0;
  int   nOverrun = 0;
  int   nSofErr  = 0;
  int   lastCyc;
  int   acc11;
  obs_t obsQ[$];
  vec_t vecs[7];

  always @(posedge clk) cycCnt++;

  always @(negedge clk) begin
    if (o_patch_valid) obsQ.push_back('{o_patch, o_patch_sof, o_patch_eol, o_patch_eof, cycCnt});
    if (o_overrun) nOverrun++;
    if (o_sof_err) nSofErr++;
  end

  function automatic logic [7:0] pv(input int x, input int y);
    return 8'(16 * y + x);
  endfunction

  function automatic logic [31:0] expPatch(input int x, input int y);
    int x1;
    int y1;
    x1 = (x + 1 > W - 1) ? W - 1 : x + 1;
    y1 = (y + 1 > H - 1) ? H - 1 : y + 1;
    return {pv(x1, y1), pv(x1, y), pv(x, y1), pv(x, y)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v, input logic s);
    i_pix       = v;
    i_sof       = s;
    i_pix_valid = 1'b1;
    lastCyc     = cycCnt;
    cyc();
    i_pix_valid = 1'b0;
    i_sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    i_pix_valid = 1'b0;
    i_sof       = 1'b0;
    repeat (n) cyc();
  endtask

  // Frame from pixel index x0 of row 0; junkRow offers a stray pixel in that row's gap cycle.
  task automatic sendFrame(input int x0, input int lineGap, input int frameGap, input int junkRow);
    for (int y = 0; y < H; y++) begin
      for (int x = (y == 0) ? x0 : 0; x < W; x++) begin
        drive(pv(x, y), (x == 0 && y == 0));
        if (x == 1 && y == 1) acc11 = lastCyc;
      end
      if (y == H - 1) begin
        idle(frameGap);
      end else if (y == junkRow) begin
        i_pix       = 8'hEE;
        i_pix_valid = 1'b1;
        cyc();
        idle(lineGap - 1);
      end else begin
        idle(lineGap);
      end
    end
  endtask

  task automatic checkFrame(input int base, input string tag);
    for (int i = 0; i < W * H; i++) begin
      int x;
      int y;
      x = i % W;
      y = i / W;
      if (base + i < obsQ.size()) begin
        chk($sformatf("%s P(%0d,%0d)", tag, x, y), obsQ[base + i].data, expPatch(x, y));
        chk($sformatf("%s flags(%0d,%0d)", tag, x, y),
            {29'd0, obsQ[base + i].sof, obsQ[base + i].eol, obsQ[base + i].eof},
            {29'd0, 1'(i == 0), 1'(x == W - 1), 1'(i == W * H - 1)});
      end else begin
        chk($sformatf("%s missing patch %0d", tag, i), obsQ.size(), base + i + 1);
      end
    end
  endtask

  task automatic countFlags(input int base, output int nP, output int nS, output int nEl, output int nEf);
    nP = obsQ.size() - base;
    nS = 0;
    nEl = 0;
    nEf = 0;
    for (int i = base; i < obsQ.size(); i++) begin
      nS  += int'(obsQ[i].sof);
      nEl += int'(obsQ[i].eol);
      nEf += int'(obsQ[i].eof);
    end
  endtask

  initial begin
    int base;
    int ov0;
    int se0;
    int nP;
    int nS;
    int nEl;
    int nEf;

    vecs[0] = '{0, 0, 32'h11_01_10_00};
    vecs[1] = '{3, 0, 32'h13_03_13_03};
    vecs[2] = '{2, 2, 32'h23_23_22_22};
    vecs[3] = '{3, 2, 32'h23_23_23_23};
    vecs[4] = '{1, 1, 32'h22_12_21_11};
    vecs[5] = '{3, 1, 32'h23_13_23_13};
    vecs[6] = '{0, 2, 32'h21_21_20_20};

    i_rst       = 1'b1;
    i_pix       = '0;
    i_pix_valid = 1'b0;
    i_sof       = 1'b0;
    repeat (3) cyc();
    chk("reset in_ready", o_in_ready, 1);
    chk("reset valid", o_patch_valid, 0);
    chk("reset patch", o_patch, 0);
    chk("reset flags", {o_patch_sof, o_patch_eol, o_patch_eof, o_overrun, o_sof_err}, 0);
    i_rst = 1'b0;
    idle(2);

    // Clean frame with one-cycle line gaps.
    base = obsQ.size();
    ov0  = nOverrun;
    sendFrame(0, 1, 5, -1);
    idle(8);
    countFlags(base, nP, nS, nEl, nEf);
    chk("clean count", nP, 12);
    chk("clean sof", nS, 1);
    chk("clean eol", nEl, 3);
    chk("clean eof", nEf, 1);
    chk("clean overrun", nOverrun - ov0, 0);
    for (int i = 0; i < 7; i++) begin
      int idx;
      idx = base + vecs[i].y * W + vecs[i].x;
      if (idx < obsQ.size()) chk($sformatf("vec P(%0d,%0d)", vecs[i].x, vecs[i].y), obsQ[idx].data, vecs[i].exp);
      else chk($sformatf("vec P(%0d,%0d) missing", vecs[i].x, vecs[i].y), obsQ.size(), idx + 1);
    end
    if (base + 3 < obsQ.size()) begin
      chk("latency sof", obsQ[base].cyc, acc11 + 2);
      chk("latency edge", obsQ[base + 3].cyc, acc11 + 5);
    end else begin
      chk("latency patches missing", obsQ.size(), base + 4);
    end
    checkFrame(base, "clean");

    // Stray pixel during the EDGE cycle of row 1.
    base = obsQ.size();
    ov0  = nOverrun;
    se0  = nSofErr;
    sendFrame(0, 1, 5, 1);
    idle(8);
    chk("overrun pulses", nOverrun - ov0, 1);
    chk("overrun sof_err", nSofErr - se0, 0);
    chk("overrun count", obsQ.size() - base, 12);
    checkFrame(base, "overrun");

    // Start-of-frame arriving at (2,1) aborts the frame and restarts.
    base = obsQ.size();
    se0  = nSofErr;
    for (int x = 0; x < W; x++) drive(pv(x, 0), (x == 0));
    idle(1);
    drive(pv(0, 1), 1'b0);
    drive(pv(1, 1), 1'b0);
    drive(pv(0, 0), 1'b1);
    sendFrame(1, 1, 5, -1);
    idle(8);
    countFlags(base, nP, nS, nEl, nEf);
    chk("resync sof_err", nSofErr - se0, 1);
    chk("resync count", nP, 13);
    chk("resync eof", nEf, 1);
    chk("resync sof", nS, 2);
    if (base < obsQ.size()) chk("resync aborted P00", obsQ[base].data, 32'h11_01_10_00);
    checkFrame(base + 1, "resync");

    // Two frames separated by exactly five idle cycles.
    base = obsQ.size();
    ov0  = nOverrun;
    sendFrame(0, 1, 5, -1);
    sendFrame(0, 1, 5, -1);
    idle(8);
    countFlags(base, nP, nS, nEl, nEf);
    chk("b2b overrun", nOverrun - ov0, 0);
    chk("b2b count", nP, 24);
    chk("b2b sof", nS, 2);
    chk("b2b eof", nEf, 2);
    checkFrame(base, "b2b0");
    checkFrame(base + 12, "b2b1");

    // Reset while the last row is being flushed.
    sendFrame(0, 1, 0, -1);
    idle(2);
    i_rst = 1'b1;
    cyc();
    chk("rst flush valid", o_patch_valid, 0);
    chk("rst flush ready", o_in_ready, 1);
    i_rst = 1'b0;
    idle(3);
    base = obsQ.size();
    sendFrame(0, 1, 5, -1);
    idle(8);
    countFlags(base, nP, nS, nEl, nEf);
    chk("post-reset count", nP, 12);
    chk("post-reset eof", nEf, 1);
    checkFrame(base, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
